// File: rtl/uart_cmd_responder.sv
// UART command responder: byte-framed register read/write with ACK/NAK replies and inter-byte timeout.
// Optional frame checksum byte enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_responder #(
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 5208000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       tx_active,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       cmd_err,
  output logic [1:0] err_code,
  output logic [2:0] dbg_state
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0] NUM_REGS_L = 9'(NUM_REGS);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

`ifdef UART_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, GET_ADDR = 3'd1, GET_DATA = 3'd2, GET_CSUM = 3'd3,
    EXEC = 3'd4, SEND = 3'd5, WAIT_TX = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, GET_ADDR = 3'd1, GET_DATA = 3'd2,
    EXEC = 3'd4, SEND = 3'd5, WAIT_TX = 3'd6
  } state_t;
`endif

  state_t           state_q, state_d;
  logic             op_wr_q, op_wr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             nak_q, nak_d;
  logic [1:0]       nak_code_q, nak_code_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             cmd_err_q, cmd_err_d;
  logic [1:0]       err_code_q, err_code_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif
  logic [7:0]       regs_q [NUM_REGS];
  logic             reg_we;
  logic [IDX_W-1:0] reg_idx;
  logic             in_range;
  logic [7:0]       rd_val;
  logic             expired;

  // Range check uses the full address; the index is only meaningful once it passes.
  assign in_range = ({1'b0, addr_q} < NUM_REGS_L);
  assign reg_idx  = addr_q[IDX_W-1:0];
  assign rd_val   = in_range ? regs_q[reg_idx] : 8'h00;
  assign expired  = (timer_q == TMR_LIMIT);

  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    nak_d      = nak_q;
    nak_code_d = nak_code_q;
    timer_d    = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    cmd_err_d  = 1'b0;
    err_code_d = err_code_q;
    reg_we     = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        nak_d = 1'b0;
        if (rx_done) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            op_wr_d = (rx_data == OP_WR);
            state_d = GET_ADDR;
`ifdef UART_CMD_CHECKSUM_EN
            csum_d  = rx_data;
`endif
          end else begin
            nak_d      = 1'b1;
            nak_code_d = 2'd1;
            state_d    = EXEC;
          end
        end
      end
      GET_ADDR: begin
        if (rx_done) begin
          addr_d = rx_data;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
          state_d = op_wr_q ? GET_DATA : GET_CSUM;
`else
          state_d = op_wr_q ? GET_DATA : EXEC;
`endif
        end else if (expired) begin
          state_d    = IDLE;
          cmd_err_d  = 1'b1;
          err_code_d = 2'd2;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GET_DATA: begin
        if (rx_done) begin
          data_d = rx_data;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
          state_d = GET_CSUM;
`else
          state_d = EXEC;
`endif
        end else if (expired) begin
          state_d    = IDLE;
          cmd_err_d  = 1'b1;
          err_code_d = 2'd2;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      GET_CSUM: begin
        if (rx_done) begin
          if (rx_data != csum_q) begin
            nak_d      = 1'b1;
            nak_code_d = 2'd3;
          end
          state_d = EXEC;
        end else if (expired) begin
          state_d    = IDLE;
          cmd_err_d  = 1'b1;
          err_code_d = 2'd2;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      EXEC: begin
        state_d    = SEND;
        tx_start_d = 1'b1;
        if (nak_q) begin
          tx_data_d  = NAK;
          cmd_err_d  = 1'b1;
          err_code_d = nak_code_q;
        end else if (!in_range) begin
          tx_data_d  = NAK;
          cmd_err_d  = 1'b1;
          err_code_d = 2'd1;
        end else if (op_wr_q) begin
          reg_we    = 1'b1;
          tx_data_d = ACK;
        end else begin
          tx_data_d = rd_val;
        end
      end
      SEND: begin
        if (tx_active) state_d = WAIT_TX;
        else           tx_start_d = 1'b1;
      end
      WAIT_TX: begin
        if (!tx_active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A byte arriving while a reply is in flight is dropped; the frame in progress continues.
    if (rx_done && (state_q == EXEC || state_q == SEND || state_q == WAIT_TX)) begin
      cmd_err_d  = 1'b1;
      err_code_d = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      nak_q      <= 1'b0;
      nak_code_q <= '0;
      timer_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      cmd_err_q  <= 1'b0;
      err_code_q <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q     <= '0;
`endif
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      nak_q      <= nak_d;
      nak_code_q <= nak_code_d;
      timer_q    <= timer_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      cmd_err_q  <= cmd_err_d;
      err_code_q <= err_code_d;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
      if (reg_we) regs_q[reg_idx] <= data_q;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign busy      = (state_q != IDLE);
  assign cmd_err   = cmd_err_q;
  assign err_code  = err_code_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: byte driver, transmitter model, reply scoreboard.
module tb_uart_cmd_responder;
  localparam int NR = 16;
  localparam int TO = 40;
  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_active;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       cmd_err;
  logic [1:0] err_code;
  logic [2:0] dbg_state;

  logic [7:0] exp_q[$];
  int         lat_q[$];
  logic [7:0] model_regs [NR];
  logic [7:0] mon_d0;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int err_cnt = 0;
  int start_cnt = 0;
  int tx_delay = 1;
  int last_cyc = 0;

  uart_cmd_responder #(.NUM_REGS(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .tx_active(tx_active), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .cmd_err(cmd_err), .err_code(err_code), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cmd_err) err_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(negedge clk);
    rx_data  = b;
    rx_done  = 1'b1;
    last_cyc = cyc;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] v);
    exp_q.push_back(v);
    lat_q.push_back(last_cyc + 2);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_idle", busy, 0);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic [7:0] rep);
    send_byte(OP_WR);
    send_byte(a);
    send_byte(d);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(OP_WR ^ a ^ d);
`endif
    push_exp(rep);
    wait_idle();
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] rep);
    send_byte(OP_RD);
    send_byte(a);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(OP_RD ^ a);
`endif
    push_exp(rep);
    wait_idle();
  endtask

  // transmitter model and reply scoreboard
  initial begin
    tx_active = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
        mon_d0 = tx_data;
        start_cnt++;
        if (lat_q.size() > 0) check_eq("start_latency", cyc, lat_q.pop_front());
        else                  check_eq("unexpected_start", tx_start, 0);
        for (int i = 0; i < tx_delay; i++) begin
          @(negedge clk);
          check_eq("start_hold", {tx_start, tx_data}, {1'b1, mon_d0});
        end
        tx_active = 1'b1;
        @(negedge clk);
        check_eq("start_drop", tx_start, 0);
        repeat (3) @(negedge clk);
        tx_active = 1'b0;
        check_eq("data_held", tx_data, mon_d0);
        if (exp_q.size() > 0) check_eq("reply", tx_data, exp_q.pop_front());
        else                  check_eq("unexpected_reply", exp_q.size(), 1);
      end
    end
  end

  initial begin
    int e0, s0, n;
    logic [7:0] a, d;
    rst = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    for (int i = 0; i < NR; i++) model_regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cmd_err", cmd_err, 0);
    check_eq("rst_err_code", err_code, 0);

    e0 = err_cnt;
    do_write(8'h03, 8'hA5, ACK);
    model_regs[3] = 8'hA5;
    do_read(8'h03, 8'hA5);
    check_eq("good_no_err", err_cnt - e0, 0);

    tx_delay = 5;
    do_write(8'h05, 8'h3C, ACK);
    model_regs[5] = 8'h3C;
    tx_delay = 1;

    e0 = err_cnt;
    do_write(8'h10, 8'h11, NAK);
    check_eq("oor_err_pulse", err_cnt - e0, 1);
    check_eq("oor_err_code", err_code, 1);
    do_read(8'h00, model_regs[0]);
    do_write(8'h0F, 8'h5A, ACK);
    model_regs[15] = 8'h5A;
    do_read(8'h0F, 8'h5A);
    e0 = err_cnt;
    do_read(8'hFF, NAK);
    check_eq("oor_rd_err", err_cnt - e0, 1);

    e0 = err_cnt;
    send_byte(8'h41);
    push_exp(NAK);
    wait_idle();
    check_eq("badop_err_pulse", err_cnt - e0, 1);
    check_eq("badop_err_code", err_code, 1);

    e0 = err_cnt;
    s0 = start_cnt;
    send_byte(OP_RD);
    repeat (5) @(negedge clk);
    check_eq("to_busy_mid", busy, 1);
    repeat (TO + 5) @(negedge clk);
    check_eq("to_busy", busy, 0);
    check_eq("to_err_pulse", err_cnt - e0, 1);
    check_eq("to_err_code", err_code, 2);
    check_eq("to_no_start", start_cnt - s0, 0);

    // Address byte lands in the exact expiry cycle and must be accepted.
    e0 = err_cnt;
    @(negedge clk);
    rx_data = OP_RD;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (TO) @(negedge clk);
    rx_data  = 8'h03;
    rx_done  = 1'b1;
    last_cyc = cyc;
    @(negedge clk);
    rx_done = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(OP_RD ^ 8'h03);
`endif
    push_exp(model_regs[3]);
    wait_idle();
    check_eq("race_no_err", err_cnt - e0, 0);

    e0 = err_cnt;
    tx_delay = 2;
    send_byte(OP_WR);
    send_byte(8'h07);
    send_byte(8'h99);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(OP_WR ^ 8'h07 ^ 8'h99);
`endif
    push_exp(ACK);
    model_regs[7] = 8'h99;
    n = 0;
    while (!tx_active && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("ovr_tx_active", tx_active, 1);
    @(negedge clk);
    rx_data = OP_RD;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    wait_idle();
    check_eq("ovr_err_pulse", err_cnt - e0, 1);
    check_eq("ovr_err_code", err_code, 3);
    tx_delay = 1;
    do_read(8'h07, 8'h99);

    for (int k = 0; k < 6; k++) begin
      a = 8'($urandom_range(0, NR - 1));
      d = 8'($urandom_range(0, 255));
      tx_delay = $urandom_range(0, 3);
      do_write(a, d, ACK);
      model_regs[a[3:0]] = d;
      do_read(a, model_regs[a[3:0]]);
    end
    tx_delay = 1;

`ifdef UART_CMD_CHECKSUM_EN
    send_byte(OP_WR);
    send_byte(8'h01);
    send_byte(8'h22);
    send_byte(8'h74);
    push_exp(ACK);
    wait_idle();
    model_regs[1] = 8'h22;
    e0 = err_cnt;
    send_byte(OP_WR);
    send_byte(8'h01);
    send_byte(8'h33);
    send_byte(8'h00);
    push_exp(NAK);
    wait_idle();
    check_eq("csum_err_pulse", err_cnt - e0, 1);
    check_eq("csum_err_code", err_code, 3);
    do_read(8'h01, 8'h22);
`endif

    // Reset in the middle of a write frame abandons it and clears the register file.
    send_byte(OP_WR);
    send_byte(8'h07);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_tx_start", tx_start, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_err_code", err_code, 0);
    for (int i = 0; i < NR; i++) model_regs[i] = 8'h00;
    do_read(8'h07, model_regs[7]);
    do_read(8'h03, model_regs[3]);

    repeat (5) @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: register-file depth, range 2..256.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5208000: maximum clk cycles allowed between bytes of one command.
REQ-003 SHALL have port clk, input, 1: sole clock; one clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port rx_done, input, 1: single-cycle strobe, rx_data valid.
REQ-006 SHALL have port rx_data, input, 8: received byte.
REQ-007 SHALL have port tx_active, input, 1: transmitter busy.
REQ-008 SHALL have port tx_start, output, 1: request transmission of tx_data.
REQ-009 SHALL have port tx_data, output, 8: reply byte.
REQ-010 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-011 SHALL have port cmd_err, output, 1: single-cycle error pulse.
REQ-012 SHALL have port err_code, output, 2: cause of last error (0 none, 1 bad opcode/addr, 2 timeout, 3 overrun/checksum); held until the next error.

Function
REQ-013 SHALL support command frames: write = 0x57, addr, data; read = 0x52, addr.
REQ-014 SHALL use FSM states IDLE, GET_ADDR, GET_DATA, GET_CSUM (macro only), EXEC, SEND, WAIT_TX.
REQ-015 In IDLE, rx_done with 0x57 or 0x52 SHALL latch the opcode and go to GET_ADDR; any other byte SHALL go to EXEC with NAK pending, err_code=1.
REQ-016 GET_ADDR on rx_done SHALL latch addr, then go to GET_DATA (write), GET_CSUM (read, macro on) or EXEC (read).
REQ-017 GET_DATA on rx_done SHALL latch data, then go to GET_CSUM (macro on) or EXEC.
REQ-018 EXEC SHALL last exactly one cycle.
REQ-019 In EXEC, a write with addr < NUM_REGS SHALL update regs[addr] and select reply 0x06.
REQ-020 In EXEC, a read with addr < NUM_REGS SHALL select reply regs[addr].
REQ-021 In EXEC, addr >= NUM_REGS SHALL select reply 0x15, perform no write, and pulse cmd_err with err_code=1.
REQ-022 Latency: with the final byte's rx_done in cycle N, tx_start SHALL first be high in cycle N+2.
REQ-023 SEND SHALL hold tx_start high with tx_data stable until tx_active is sampled high, then go to WAIT_TX with tx_start low.
REQ-024 WAIT_TX SHALL return to IDLE on the first cycle tx_active is low; tx_data SHALL be held throughout.
REQ-025 The timeout counter SHALL clear on every accepted byte and count only in GET_* states.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE with no reply, pulse cmd_err, and set err_code=2.
REQ-027 rx_done in the same cycle as timeout expiry SHALL win: the byte is accepted and the counter cleared.
REQ-028 rx_done in EXEC, SEND or WAIT_TX SHALL drop the byte, pulse cmd_err, set err_code=3, and leave the state unchanged.
REQ-029 Address comparison SHALL use the full 8-bit addr; the register index SHALL use the low ceil(log2(NUM_REGS)) bits only after the range check passes.

Reset
REQ-030 With rst high at a clock edge, the block SHALL go to IDLE.
REQ-031 Reset SHALL clear tx_start, tx_data, busy, cmd_err, err_code, the timeout counter and all regs to 0.
REQ-032 Reset asserted mid-command or mid-reply SHALL abandon the frame without completing the write; tx_start SHALL be low in the first cycle after reset.

Configuration
REQ-033 Macro UART_CMD_CHECKSUM_EN SHALL control frame checksums.
REQ-034 With UART_CMD_CHECKSUM_EN defined, every command SHALL carry a final byte equal to the XOR of all preceding frame bytes, received in GET_CSUM.
REQ-035 With UART_CMD_CHECKSUM_EN defined, a checksum mismatch SHALL select reply 0x15, perform no write, pulse cmd_err and set err_code=3.
REQ-036 Without UART_CMD_CHECKSUM_EN, the GET_CSUM state and its logic SHALL be absent, and frames SHALL be as in REQ-013.

Verification
REQ-037 Bench SHALL drive write 0x57,0x03,0xA5 and require reply 0x06; a following read 0x52,0x03 SHALL return 0xA5.
REQ-038 Bench SHALL drive write 0x57,0x10,0x11 (NUM_REGS=16) and require reply 0x15, cmd_err pulse, err_code=1, and regs unchanged.
REQ-039 Bench SHALL drive 0x52 then no byte for TIMEOUT_CYCLES and require no tx_start, cmd_err pulse, err_code=2, and busy low.
REQ-040 Bench SHALL drive an rx_done during WAIT_TX and require the byte dropped, err_code=3, and the reply completing normally.
REQ-041 Bench SHALL check tx_start held across a delayed tx_active rise of 5 cycles, and tx_start high in cycle N+2 after the final byte.
REQ-042 With the macro on, bench SHALL drive 0x57,0x01,0x22,0x74 and require reply 0x06; checksum 0x00 SHALL require reply 0x15 with no write.
